// File: rtl/icu_sequencer_if.sv
// Interrupt control unit request/response bundle.
//   master side (requester/pipeline): int_req, stall, pc_in, flags_in
//   slave side (icu_sequencer):       int_flag, int_ack, push_data,
//                                     vec_read, vec_addr, pc_load
interface icu_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned FLAG_WIDTH = 3
);
  logic                  int_req;
  logic                  stall;
  logic [PC_WIDTH-1:0]   pc_in;
  logic [FLAG_WIDTH-1:0] flags_in;
  logic                  int_flag;
  logic                  int_ack;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  vec_read;
  logic [PC_WIDTH-1:0]   vec_addr;
  logic                  pc_load;

  modport master (
    output int_req, stall, pc_in, flags_in,
    input  int_flag, int_ack, push_data, vec_read, vec_addr, pc_load
  );

  modport slave (
    input  int_req, stall, pc_in, flags_in,
    output int_flag, int_ack, push_data, vec_read, vec_addr, pc_load
  );
endinterface

// File: rtl/icu_sequencer.sv
// Interrupt control unit sequencer. On an accepted interrupt it takes over
// the shared ID/EX control lines for a fixed 5-state sequence: push PC high
// half, push PC low half, push flags, fetch the ISR vector, branch.
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   bus            icu_sequencer_if.slave: request inputs, ICU-owned outputs
//   alu_function, branch, data_read, data_write, DMW, stack_operation,
//   push_pop, write_sp
//                  shared control lines, driven only while int_flag=1,
//                  otherwise high impedance so the control unit can drive them
// PC_WIDTH must equal 2*DATA_WIDTH.
module icu_sequencer #(
  parameter int unsigned          DATA_WIDTH      = 16,
  parameter int unsigned          PC_WIDTH        = 32,
  parameter int unsigned          FLAG_WIDTH      = 3,
  parameter logic [PC_WIDTH-1:0]  INT_VECTOR_ADDR = '0
) (
  input  logic           clk,
  input  logic           rst,
  icu_sequencer_if.slave bus,
  output wire [3:0]      alu_function,
  output wire            branch,
  output wire            data_read,
  output wire            data_write,
  output wire            DMW,
  output wire            stack_operation,
  output wire            push_pop,
  output wire            write_sp
);

  localparam logic [3:0] ALU_PUSH = 4'b0100;
  localparam logic [3:0] ALU_JUMP = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLG,
    FETCH_VEC,
    JUMP
  } state_t;

  typedef struct packed {
    logic                  int_flag;
    logic                  int_ack;
    logic                  vec_read;
    logic                  pc_load;
    logic [3:0]            alu_function;
    logic                  branch;
    logic                  data_read;
    logic                  data_write;
    logic                  dmw;
    logic                  stack_operation;
    logic                  push_pop;
    logic                  write_sp;
    logic [DATA_WIDTH-1:0] push_data;
  } out_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  out_t                  out_q, out_d;
  logic                  accept_c;

  // Next state, latches and next outputs. Under stall the next state and
  // latches equal the current ones, so the registered outputs recompute to
  // the same values and everything holds.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    accept_c  = 1'b0;
    out_d     = '0;

    if (!bus.stall) begin
      unique case (state_q)
        IDLE: begin
          if (bus.int_req || pending_q) begin
            accept_c = 1'b1;
            state_d  = PUSH_HI;
            pc_d     = bus.pc_in;
            flags_d  = bus.flags_in;
          end
        end
        PUSH_HI:   state_d = PUSH_LO;
        PUSH_LO:   state_d = PUSH_FLG;
        PUSH_FLG:  state_d = FETCH_VEC;
        FETCH_VEC: state_d = JUMP;
        JUMP:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end

    // Any request not consumed by an accept is remembered; repeats collapse.
    if (accept_c) begin
      pending_d = 1'b0;
    end else if (bus.int_req) begin
      pending_d = 1'b1;
    end

    out_d.int_flag = (state_d != IDLE);
    unique case (state_d)
      PUSH_HI, PUSH_LO, PUSH_FLG: begin
        out_d.alu_function    = ALU_PUSH;
        out_d.dmw             = 1'b1;
        out_d.stack_operation = 1'b1;
        out_d.push_pop        = 1'b1;
        out_d.write_sp        = 1'b1;
        if (state_d == PUSH_HI) begin
          out_d.push_data = pc_d[PC_WIDTH-1 -: DATA_WIDTH];
        end else if (state_d == PUSH_LO) begin
          out_d.push_data = pc_d[DATA_WIDTH-1:0];
        end else begin
          out_d.push_data = DATA_WIDTH'(flags_d);
        end
      end
      FETCH_VEC: out_d.vec_read = 1'b1;
      JUMP: begin
        out_d.alu_function = ALU_JUMP;
        out_d.branch       = 1'b1;
        out_d.pc_load      = 1'b1;
        out_d.int_ack      = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      pc_q      <= '0;
      flags_q   <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      out_q     <= out_d;
    end
  end

  assign bus.int_flag  = out_q.int_flag;
  assign bus.int_ack   = out_q.int_ack;
  assign bus.vec_read  = out_q.vec_read;
  assign bus.pc_load   = out_q.pc_load;
  assign bus.push_data = out_q.push_data;
  assign bus.vec_addr  = INT_VECTOR_ADDR;

  // Shared lines are released to the control unit whenever int_flag is low.
  assign alu_function    = out_q.int_flag ? out_q.alu_function    : 4'bzzzz;
  assign branch          = out_q.int_flag ? out_q.branch          : 1'bz;
  assign data_read       = out_q.int_flag ? out_q.data_read       : 1'bz;
  assign data_write      = out_q.int_flag ? out_q.data_write      : 1'bz;
  assign DMW             = out_q.int_flag ? out_q.dmw             : 1'bz;
  assign stack_operation = out_q.int_flag ? out_q.stack_operation : 1'bz;
  assign push_pop        = out_q.int_flag ? out_q.push_pop        : 1'bz;
  assign write_sp        = out_q.int_flag ? out_q.write_sp        : 1'bz;

endmodule

// File: tb/tb_icu_sequencer.sv
// Bench for icu_sequencer: directed scenarios followed by random traffic.
// A transaction-level model queues the five expected output beats of each
// accepted interrupt; a negedge monitor pops and compares them.
module tb_icu_sequencer;

  localparam logic [31:0] VEC = 32'h0000_0000;

  logic clk;
  logic rst;

  icu_sequencer_if #(.DATA_WIDTH(16), .PC_WIDTH(32), .FLAG_WIDTH(3)) bus ();

  wire [3:0] alu_function;
  wire       branch, data_read, data_write, DMW;
  wire       stack_operation, push_pop, write_sp;

  icu_sequencer #(
    .DATA_WIDTH(16), .PC_WIDTH(32), .FLAG_WIDTH(3), .INT_VECTOR_ADDR(VEC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .alu_function    (alu_function),
    .branch          (branch),
    .data_read       (data_read),
    .data_write      (data_write),
    .DMW             (DMW),
    .stack_operation (stack_operation),
    .push_pop        (push_pop),
    .write_sp        (write_sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu;
    logic        branch;
    logic        data_read;
    logic        data_write;
    logic        dmw;
    logic        stk;
    logic        pp;
    logic        wsp;
    logic        vec_read;
    logic        pc_load;
    logic        int_ack;
    logic [15:0] data;
    logic [31:0] vaddr;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    busy = 0;        // active cycles remaining in the current sequence
  bit    pending = 0;
  bit    adv_last = 0;    // last edge moved the sequence (no stall, no reset)
  bit    started = 0;
  beat_t held;

  // Expected output for beat idx (0..4) of a sequence.
  function automatic beat_t mk_beat(int unsigned idx, logic [31:0] pc, logic [2:0] f);
    beat_t b;
    b = '0;
    b.vaddr = VEC;
    if (idx < 3) begin
      b.alu = 4'b0100;
      b.dmw = 1'b1;
      b.stk = 1'b1;
      b.pp  = 1'b1;
      b.wsp = 1'b1;
      if (idx == 0)      b.data = pc[31:16];
      else if (idx == 1) b.data = pc[15:0];
      else               b.data = {13'b0, f};
    end else if (idx == 3) begin
      b.vec_read = 1'b1;
    end else begin
      b.alu     = 4'b0011;
      b.branch  = 1'b1;
      b.pc_load = 1'b1;
      b.int_ack = 1'b1;
    end
    return b;
  endfunction

  // Reference model, advanced on every clock edge from the sampled inputs.
  always @(posedge clk) begin
    adv_last = !bus.stall && !rst;
    if (rst) begin
      busy    = 0;
      pending = 0;
      exp_q.delete();
    end else if (bus.stall) begin
      if (bus.int_req) pending = 1;
    end else if (busy > 0) begin
      busy = busy - 1;
      if (bus.int_req) pending = 1;
    end else if (bus.int_req || pending) begin
      busy    = 5;
      pending = 0;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk_beat(i, bus.pc_in, bus.flags_in));
    end
    started = 1;
  end

  // Monitor: compare DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      beat_t act;
      beat_t exp;
      logic [11:0] sh;
      bit drives_one;
      act.alu        = alu_function;
      act.branch     = branch;
      act.data_read  = data_read;
      act.data_write = data_write;
      act.dmw        = DMW;
      act.stk        = stack_operation;
      act.pp         = push_pop;
      act.wsp        = write_sp;
      act.vec_read   = bus.vec_read;
      act.pc_load    = bus.pc_load;
      act.int_ack    = bus.int_ack;
      act.data       = bus.push_data;
      act.vaddr      = bus.vec_addr;

      checks++;
      if (bus.int_flag !== (busy > 0)) begin
        errors++;
        $display("FAIL int_flag @%0t: actual=%b expected=%b", $time, bus.int_flag, busy > 0);
      end

      if (busy > 0) begin
        if (adv_last) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_underflow @%0t: actual=%h expected=<none>", $time, act);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL beat @%0t: actual=%h expected=%h", $time, act, exp);
            end
          end
          held = act;
        end else begin
          checks++;
          if (act !== held) begin
            errors++;
            $display("FAIL stall_hold @%0t: actual=%h expected=%h", $time, act, held);
          end
        end
      end else begin
        sh = {alu_function, branch, data_read, data_write, DMW,
              stack_operation, push_pop, write_sp, 1'b0};
        drives_one = 0;
        for (int i = 0; i < 12; i++) if (sh[i] === 1'b1) drives_one = 1;
        checks++;
        if (drives_one || bus.int_ack !== 1'b0 || bus.vec_read !== 1'b0 ||
            bus.pc_load !== 1'b0 || bus.push_data !== 16'h0) begin
          errors++;
          $display("FAIL idle_outputs @%0t: actual shared=%b ack=%b vr=%b pcl=%b pd=%h expected shared released, rest 0",
                   $time, sh, bus.int_ack, bus.vec_read, bus.pc_load, bus.push_data);
        end
      end
    end
  end

  // Apply one cycle of inputs, then advance past the next rising edge.
  task automatic cyc(input bit req, input bit stl, input bit r,
                     input logic [31:0] pc, input logic [2:0] fl);
    bus.int_req  = req;
    bus.stall    = stl;
    rst          = r;
    bus.pc_in    = pc;
    bus.flags_in = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.int_req  = 1'b0;
    bus.stall    = 1'b0;
    bus.pc_in    = '0;
    bus.flags_in = '0;
    rst          = 1'b1;
    cyc(0, 0, 1, 32'h0, 3'h0);
    cyc(0, 0, 1, 32'h0, 3'h0);

    // Quiet after reset.
    repeat (10) cyc(0, 0, 0, 32'hDEAD_BEEF, 3'h7);

    // Basic sequence; pc_in changes right after accept.
    cyc(1, 0, 0, 32'h1234_5678, 3'b101);
    cyc(0, 0, 0, 32'hFFFF_0000, 3'b010);
    repeat (7) cyc(0, 0, 0, 32'hA5A5_5A5A, 3'b011);

    // Stall three cycles while in PUSH_LO.
    cyc(1, 0, 0, 32'hCAFE_F00D, 3'b110);
    cyc(0, 0, 0, 32'h0, 3'h0);
    repeat (3) cyc(0, 1, 0, 32'h0, 3'h0);
    repeat (7) cyc(0, 0, 0, 32'h0, 3'h0);

    // Requests during PUSH_FLG and FETCH_VEC collapse to one follow-up.
    cyc(1, 0, 0, 32'h0BAD_C0DE, 3'b001);
    cyc(0, 0, 0, 32'h0, 3'h0);
    cyc(0, 0, 0, 32'h0, 3'h0);
    cyc(1, 0, 0, 32'h1111_2222, 3'b100);
    cyc(1, 0, 0, 32'h3333_4444, 3'b111);
    repeat (12) cyc(0, 0, 0, 32'h5555_6666, 3'b010);

    // Reset while in FETCH_VEC aborts the sequence.
    cyc(1, 0, 0, 32'h8765_4321, 3'b011);
    repeat (3) cyc(0, 0, 0, 32'h0, 3'h0);
    cyc(0, 0, 1, 32'h0, 3'h0);
    repeat (6) cyc(0, 0, 0, 32'h0, 3'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 249) == 0, $urandom, 3'($urandom_range(0, 7)));
    end
    repeat (12) cyc(0, 0, 0, 32'h0, 3'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d beats left expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
